// File: rtl/nn_mac_scheduler_if.sv
// Handshake bundle between the MAC scheduler and the nn_adder datapath.
// The scheduler side uses the master modport, the adder side the slave.
interface nn_mac_scheduler_if;
    logic        ct_valid_out;
    logic        ct_ready_in;
    logic [31:0] ct_out;
    logic [9:0]  idx_k_out;
    logic [9:0]  idx_N_out;
    logic        weights_valid_out;
    logic        weights_ready_in;
    logic [2:0]  weights_out;
    logic [5:0]  weights_idx_out;
    logic        mem_valid_out;
    logic        mem_ready_in;
    logic [31:0] mem_out;
    logic        sum_valid_in;
    logic        sum_ready_out;
    logic [31:0] sum_in;
    logic [9:0]  sum_idx_k_in;
    logic [9:0]  sum_idx_N_in;
    logic [5:0]  sum_idx_w_in;

    modport master (
        output ct_valid_out, ct_out, idx_k_out, idx_N_out,
        output weights_valid_out, weights_out, weights_idx_out,
        output mem_valid_out, mem_out, sum_ready_out,
        input  ct_ready_in, weights_ready_in, mem_ready_in,
        input  sum_valid_in, sum_in, sum_idx_k_in, sum_idx_N_in, sum_idx_w_in
    );

    modport slave (
        input  ct_valid_out, ct_out, idx_k_out, idx_N_out,
        input  weights_valid_out, weights_out, weights_idx_out,
        input  mem_valid_out, mem_out, sum_ready_out,
        output ct_ready_in, weights_ready_in, mem_ready_in,
        output sum_valid_in, sum_in, sum_idx_k_in, sum_idx_N_in, sum_idx_w_in
    );
endinterface

// File: rtl/nn_mac_scheduler.sv
// Sequencer for the nn_adder MAC datapath: walks every (N, k, w) triple,
// fetches operands from block RAM, offers them and writes back each sum.
module nn_mac_scheduler #(
    parameter int K_VAL     = 501,
    parameter int DEPTH     = 100,
    parameter int OUT_NODES = 10,
    parameter int RD_LAT    = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [15:0] ct_addr_out,
    input  logic [31:0] ct_rd_data_in,
    output logic [9:0]  w_addr_out,
    input  logic [2:0]  w_rd_data_in,
    output logic [12:0] acc_rd_addr_out,
    input  logic [31:0] acc_rd_data_in,
    output logic        acc_wr_en_out,
    output logic [12:0] acc_wr_addr_out,
    output logic [31:0] acc_wr_data_out,
    nn_mac_scheduler_if.master adder
);

    typedef enum logic [2:0] {
        IDLE, CT_FETCH, CT_OFFER, OP_FETCH,
        OP_OFFER, SUM_WAIT, WRITE, DONE
    } state_t;

    localparam logic [9:0] N_LAST   = 10'(DEPTH - 1);
    localparam logic [9:0] K_LAST   = 10'(K_VAL - 1);
    localparam logic [5:0] W_LAST   = 6'(OUT_NODES - 1);
    localparam logic [7:0] WAIT_END = 8'(RD_LAT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [9:0]  n_cnt;
    logic [9:0]  k_cnt;
    logic [5:0]  w_cnt;
    logic [9:0]  w_base;

    // Index outputs come straight from the loop counters, which only move in WRITE.
    assign adder.idx_k_out       = k_cnt;
    assign adder.idx_N_out       = n_cnt;
    assign adder.weights_idx_out = w_cnt;

    // Main sequencer: loop counters, incremental addresses and handshakes.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state                   <= IDLE;
            wait_cnt                <= '0;
            n_cnt                   <= '0;
            k_cnt                   <= '0;
            w_cnt                   <= '0;
            w_base                  <= '0;
            busy_out                <= 1'b0;
            done_out                <= 1'b0;
            err_out                 <= 1'b0;
            ct_addr_out             <= '0;
            w_addr_out              <= '0;
            acc_rd_addr_out         <= '0;
            acc_wr_en_out           <= 1'b0;
            acc_wr_addr_out         <= '0;
            acc_wr_data_out         <= '0;
            adder.ct_valid_out      <= 1'b0;
            adder.ct_out            <= '0;
            adder.weights_valid_out <= 1'b0;
            adder.weights_out       <= '0;
            adder.mem_valid_out     <= 1'b0;
            adder.mem_out           <= '0;
            adder.sum_ready_out     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    n_cnt           <= '0;
                    k_cnt           <= '0;
                    w_cnt           <= '0;
                    w_base          <= '0;
                    wait_cnt        <= '0;
                    ct_addr_out     <= '0;
                    w_addr_out      <= '0;
                    acc_rd_addr_out <= '0;
                    if (start_in) begin
                        busy_out <= 1'b1;
                        err_out  <= 1'b0;
                        state    <= CT_FETCH;
                    end
                end
                CT_FETCH: begin
                    if (wait_cnt == WAIT_END) begin
                        adder.ct_out       <= ct_rd_data_in;
                        adder.ct_valid_out <= 1'b1;
                        state              <= CT_OFFER;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CT_OFFER: begin
                    if (adder.ct_ready_in) begin
                        adder.ct_valid_out <= 1'b0;
                        wait_cnt           <= '0;
                        state              <= OP_FETCH;
                    end
                end
                OP_FETCH: begin
                    if (wait_cnt == WAIT_END) begin
                        adder.weights_out       <= w_rd_data_in;
                        // Row 0 starts every accumulator from zero.
                        adder.mem_out           <= (n_cnt == '0) ? '0 : acc_rd_data_in;
                        adder.weights_valid_out <= 1'b1;
                        adder.mem_valid_out     <= 1'b1;
                        state                   <= OP_OFFER;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                OP_OFFER: begin
                    if (adder.weights_ready_in && adder.mem_ready_in) begin
                        adder.weights_valid_out <= 1'b0;
                        adder.mem_valid_out     <= 1'b0;
                        adder.sum_ready_out     <= 1'b1;
                        state                   <= SUM_WAIT;
                    end
                end
                SUM_WAIT: begin
                    if (adder.sum_valid_in) begin
                        adder.sum_ready_out <= 1'b0;
                        acc_wr_en_out       <= 1'b1;
                        acc_wr_addr_out     <= acc_rd_addr_out;
                        acc_wr_data_out     <= adder.sum_in;
                        if (adder.sum_idx_k_in != k_cnt ||
                            adder.sum_idx_N_in != n_cnt ||
                            adder.sum_idx_w_in != w_cnt) begin
                            err_out <= 1'b1;
                        end
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    acc_wr_en_out <= 1'b0;
                    wait_cnt      <= '0;
                    if (w_cnt != W_LAST) begin
                        w_cnt           <= w_cnt + 6'd1;
                        w_addr_out      <= w_addr_out + 10'd1;
                        acc_rd_addr_out <= acc_rd_addr_out + 13'(K_VAL);
                        state           <= OP_FETCH;
                    end else if (k_cnt != K_LAST) begin
                        w_cnt           <= '0;
                        k_cnt           <= k_cnt + 10'd1;
                        w_addr_out      <= w_base;
                        acc_rd_addr_out <= 13'(k_cnt) + 13'd1;
                        ct_addr_out     <= ct_addr_out + 16'd1;
                        state           <= CT_FETCH;
                    end else if (n_cnt != N_LAST) begin
                        w_cnt           <= '0;
                        k_cnt           <= '0;
                        n_cnt           <= n_cnt + 10'd1;
                        w_base          <= w_base + 10'(OUT_NODES);
                        w_addr_out      <= w_base + 10'(OUT_NODES);
                        acc_rd_addr_out <= '0;
                        ct_addr_out     <= ct_addr_out + 16'd1;
                        state           <= CT_FETCH;
                    end else begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_mac_scheduler.sv
// Bench for nn_mac_scheduler: RAM models, a behavioural adder and a
// reference accumulation computed directly from the loop definition.
module tb_nn_mac_scheduler;
    localparam int K  = 3;
    localparam int D  = 2;
    localparam int O  = 2;
    localparam int RL = 2;
    localparam int NA = K * O;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_in;
    logic        start_in;
    logic        busy_out, done_out, err_out;
    logic [15:0] ct_addr_out;
    logic [31:0] ct_rd_data_in;
    logic [9:0]  w_addr_out;
    logic [2:0]  w_rd_data_in;
    logic [12:0] acc_rd_addr_out;
    logic [31:0] acc_rd_data_in;
    logic        acc_wr_en_out;
    logic [12:0] acc_wr_addr_out;
    logic [31:0] acc_wr_data_out;

    nn_mac_scheduler_if bus();

    nn_mac_scheduler #(
        .K_VAL(K), .DEPTH(D), .OUT_NODES(O), .RD_LAT(RL)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .ct_addr_out(ct_addr_out), .ct_rd_data_in(ct_rd_data_in),
        .w_addr_out(w_addr_out), .w_rd_data_in(w_rd_data_in),
        .acc_rd_addr_out(acc_rd_addr_out), .acc_rd_data_in(acc_rd_data_in),
        .acc_wr_en_out(acc_wr_en_out), .acc_wr_addr_out(acc_wr_addr_out),
        .acc_wr_data_out(acc_wr_data_out), .adder(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // RAM contents
    logic [31:0] ct_mem  [8];
    logic [2:0]  w_mem   [4];
    logic [31:0] acc_mem [8];
    logic [31:0] ref_acc [8];

    // Read model: address captured on the next edge, data valid at edge RL
    logic [15:0] ct_pipe  [RL-1];
    logic [9:0]  w_pipe   [RL-1];
    logic [12:0] acc_pipe [RL-1];
    always @(posedge clk) begin
        ct_pipe[0]  <= ct_addr_out;
        w_pipe[0]   <= w_addr_out;
        acc_pipe[0] <= acc_rd_addr_out;
        for (int i = 1; i < RL - 1; i++) begin
            ct_pipe[i]  <= ct_pipe[i-1];
            w_pipe[i]   <= w_pipe[i-1];
            acc_pipe[i] <= acc_pipe[i-1];
        end
    end
    assign ct_rd_data_in  = (ct_pipe[RL-2] < 16'(K*D)) ?
                            ct_mem[ct_pipe[RL-2][2:0]] : 32'hDEAD_BEEF;
    assign w_rd_data_in   = (w_pipe[RL-2] < 10'(D*O)) ?
                            w_mem[w_pipe[RL-2][1:0]] : 3'b011;
    assign acc_rd_data_in = (acc_pipe[RL-2] < 13'(NA)) ?
                            acc_mem[acc_pipe[RL-2][2:0]] : 32'hBAAD_F00D;

    // Accumulator RAM writes, write/done counting, bulk fill
    logic        fill = 1'b0;
    logic [31:0] fill_val = '0;
    int wr_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 8; i++) acc_mem[i] <= fill_val + 32'(i);
        end else if (acc_wr_en_out) begin
            if (acc_wr_addr_out < 13'(NA))
                acc_mem[acc_wr_addr_out[2:0]] <= acc_wr_data_out;
            wr_cnt <= wr_cnt + 1;
        end
        if (done_out) done_cnt <= done_cnt + 1;
    end

    wire [7:0] ctl_v = {busy_out, done_out, err_out, acc_wr_en_out,
                        bus.ct_valid_out, bus.weights_valid_out,
                        bus.mem_valid_out, bus.sum_ready_out};
    wire [84:0] addr_v = {ct_addr_out, w_addr_out, acc_rd_addr_out,
                          acc_wr_addr_out, bus.idx_k_out, bus.idx_N_out,
                          bus.weights_idx_out, 7'd0};
    wire [98:0] data_v = {acc_wr_data_out, bus.ct_out, bus.weights_out,
                          bus.mem_out};
    wire [85:0] op_view = {bus.weights_valid_out, bus.mem_valid_out,
                           bus.weights_out, bus.weights_idx_out, bus.mem_out,
                           bus.idx_k_out, bus.idx_N_out, w_addr_out,
                           acc_rd_addr_out};

    // Behavioural adder controls (requests from tests, acks from the adder)
    int stall_req = 0, stall_done = 0, stall_viol = 0;
    int corr_req = 0, corr_done = 0;

    logic        hs_ct, hs_op, hs_sum, pend;
    logic [31:0] cap_ct, res;
    logic [9:0]  cap_k, cap_n;
    logic [5:0]  res_w;
    logic [9:0]  res_k, res_n;
    logic [85:0] snap;
    int          dly, stall_left, lo, hi, wt;

    initial begin
        bus.ct_ready_in = 0; bus.weights_ready_in = 0; bus.mem_ready_in = 0;
        bus.sum_valid_in = 0; bus.sum_in = 0;
        bus.sum_idx_k_in = 0; bus.sum_idx_N_in = 0; bus.sum_idx_w_in = 0;
        pend = 0; dly = 0; stall_left = 0;
        cap_ct = 0; cap_k = 0; cap_n = 0;
        forever begin
            @(negedge clk);
            hs_ct  = bus.ct_valid_out && bus.ct_ready_in;
            hs_op  = bus.weights_valid_out && bus.weights_ready_in &&
                     bus.mem_valid_out && bus.mem_ready_in;
            hs_sum = bus.sum_valid_in && bus.sum_ready_out;
            if (stall_left > 0 && op_view !== snap) stall_viol++;
            if (hs_ct) begin
                cap_ct = bus.ct_out;
                cap_k  = bus.idx_k_out;
                cap_n  = bus.idx_N_out;
            end
            if (hs_op) begin
                wt = int'($signed(bus.weights_out));
                lo = int'(bus.mem_out[15:0]) + wt * int'(cap_ct[15:0]);
                hi = int'(bus.mem_out[31:16]) + wt * int'(cap_ct[31:16]);
                res   = {16'(hi), 16'(lo)};
                res_k = cap_k;
                res_n = cap_n;
                res_w = bus.weights_idx_out;
                pend  = 1;
                dly   = $urandom_range(0, 2);
            end
            @(posedge clk);
            #1;
            if (!rst_n_in) begin
                pend = 0; stall_left = 0;
                bus.sum_valid_in = 0;
                bus.ct_ready_in = 0;
                bus.weights_ready_in = 0;
                bus.mem_ready_in = 0;
            end else begin
                if (hs_sum) bus.sum_valid_in = 0;
                if (pend) begin
                    if (dly == 0) begin
                        bus.sum_valid_in = 1;
                        bus.sum_in       = res;
                        bus.sum_idx_k_in = res_k;
                        bus.sum_idx_N_in = res_n;
                        bus.sum_idx_w_in = res_w;
                        if (corr_req > corr_done) begin
                            bus.sum_idx_w_in = res_w ^ 6'd1;
                            corr_done++;
                        end
                        pend = 0;
                    end else begin
                        dly--;
                    end
                end
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) stall_done++;
                end else if (stall_req > stall_done && bus.weights_valid_out) begin
                    stall_left = 5;
                    snap = op_view;
                end
                if (stall_left > 0) begin
                    bus.weights_ready_in = 0;
                    bus.mem_ready_in     = 0;
                end else begin
                    bus.weights_ready_in = ($urandom_range(0, 3) != 0);
                    bus.mem_ready_in     = ($urandom_range(0, 3) != 0);
                end
                bus.ct_ready_in = ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic do_reset();
        rst_n_in = 0;
        start_in = 0;
        repeat (2) @(negedge clk);
        rst_n_in = 1;
        @(negedge clk);
    endtask

    task automatic fill_acc(input logic [31:0] v);
        fill_val = v;
        fill = 1;
        @(negedge clk);
        fill = 0;
    endtask

    task automatic load(input logic [31:0] ct, input logic [2:0] w0,
                        input logic [2:0] w1);
        for (int i = 0; i < 8; i++) ct_mem[i] = ct;
        w_mem[0] = w0; w_mem[1] = w0;
        w_mem[2] = w1; w_mem[3] = w1;
    endtask

    task automatic build_ref();
        int a, l, h, s;
        for (int i = 0; i < 8; i++) ref_acc[i] = 0;
        for (int n = 0; n < D; n++)
            for (int k = 0; k < K; k++)
                for (int w = 0; w < O; w++) begin
                    a = w * K + k;
                    s = int'($signed(w_mem[n*O+w]));
                    l = int'(ref_acc[a][15:0]) + s * int'(ct_mem[n*K+k][15:0]);
                    h = int'(ref_acc[a][31:16]) + s * int'(ct_mem[n*K+k][31:16]);
                    ref_acc[a] = {16'(h), 16'(l)};
                end
    endtask

    task automatic run_pass(input bit mid_start, output int writes,
                            output int dones, output bit tmo,
                            output logic busy1, output logic err1,
                            output logic busy_d, output logic err_d);
        int w0, d0, cyc;
        w0 = wr_cnt;
        d0 = done_cnt;
        start_in = 1;
        @(negedge clk);
        start_in = 0;
        busy1 = busy_out;
        err1  = err_out;
        cyc = 0;
        while (!done_out && cyc < 4000) begin
            start_in = (mid_start && cyc == 20);
            @(negedge clk);
            cyc++;
        end
        start_in = 0;
        tmo    = !done_out;
        busy_d = busy_out;
        err_d  = err_out;
        repeat (6) @(negedge clk);
        writes = wr_cnt - w0;
        dones  = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst_n_in = 0;
        start_in = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ctl_v !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %0h expected 0", ctl_v);
        end
        n_checks++;
        if (addr_v !== 85'd0) begin
            n_fail++; $display("FAIL reset_addr: got %0h expected 0", addr_v);
        end
        n_checks++;
        if (data_v !== 99'd0) begin
            n_fail++; $display("FAIL reset_data: got %0h expected 0", data_v);
        end
        rst_n_in = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ctl_v !== 8'd0) begin
            n_fail++; $display("FAIL idle_ctl: got %0h expected 0", ctl_v);
        end
    endtask

    task automatic check_pass(input string nm, input int writes,
                              input int dones, input bit tmo,
                              input logic busy1, input logic busy_d);
        n_checks++;
        if (tmo) begin
            n_fail++; $display("FAIL %s_timeout: done_out not seen", nm);
        end
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++; $display("FAIL %s_busy_start: got %b expected 1", nm, busy1);
        end
        n_checks++;
        if (writes != 12) begin
            n_fail++; $display("FAIL %s_writes: got %0d expected 12", nm, writes);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL %s_done: got %0d expected 1", nm, dones);
        end
        n_checks++;
        if (busy_d !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_done: got %b expected 0", nm, busy_d);
        end
    endtask

    task automatic test_basic();
        int wr, dn; bit tmo; logic b1, e1, bd, ed;
        do_reset();
        load(32'h0003_0002, 3'd1, 3'd1);
        fill_acc(32'h1234_5678);
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("basic", wr, dn, tmo, b1, bd);
        n_checks++;
        if (ed !== 1'b0) begin
            n_fail++; $display("FAIL basic_err: got %b expected 0", ed);
        end
        for (int a = 0; a < NA; a++) begin
            n_checks++;
            if (acc_mem[a] !== 32'h0006_0004) begin
                n_fail++;
                $display("FAIL basic_acc[%0d]: got %h expected 00060004", a, acc_mem[a]);
            end
        end
    endtask

    task automatic test_neg_weight();
        int wr, dn; bit tmo; logic b1, e1, bd, ed;
        do_reset();
        load(32'h0003_0002, 3'd1, 3'b100);
        fill_acc(32'h5555_AAAA);
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("neg", wr, dn, tmo, b1, bd);
        for (int a = 0; a < NA; a++) begin
            n_checks++;
            if (acc_mem[a] !== 32'hFFF7_FFFA) begin
                n_fail++;
                $display("FAIL neg_acc[%0d]: got %h expected fff7fffa", a, acc_mem[a]);
            end
        end
    endtask

    task automatic test_stall();
        int wr, dn; bit tmo; logic b1, e1, bd, ed;
        do_reset();
        load(32'h0003_0002, 3'd1, 3'd1);
        fill_acc(32'h0BAD_0BAD);
        stall_req++;
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("stall", wr, dn, tmo, b1, bd);
        n_checks++;
        if (stall_done != stall_req) begin
            n_fail++; $display("FAIL stall_seen: got %0d expected %0d", stall_done, stall_req);
        end
        n_checks++;
        if (stall_viol != 0) begin
            n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol);
        end
        for (int a = 0; a < NA; a++) begin
            n_checks++;
            if (acc_mem[a] !== 32'h0006_0004) begin
                n_fail++;
                $display("FAIL stall_acc[%0d]: got %h expected 00060004", a, acc_mem[a]);
            end
        end
    endtask

    task automatic test_bad_idx();
        int wr, dn; bit tmo; logic b1, e1, bd, ed;
        do_reset();
        load(32'h0003_0002, 3'd1, 3'd1);
        corr_req++;
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("badidx", wr, dn, tmo, b1, bd);
        n_checks++;
        if (ed !== 1'b1) begin
            n_fail++; $display("FAIL badidx_err_done: got %b expected 1", ed);
        end
        n_checks++;
        if (err_out !== 1'b1) begin
            n_fail++; $display("FAIL badidx_err_sticky: got %b expected 1", err_out);
        end
        // a fresh start clears the error
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        n_checks++;
        if (e1 !== 1'b0 || ed !== 1'b0) begin
            n_fail++; $display("FAIL badidx_err_clear: got %b%b expected 00", e1, ed);
        end
    endtask

    task automatic test_reset_mid();
        int w0, cyc;
        do_reset();
        load(32'h0003_0002, 3'd1, 3'd1);
        w0 = wr_cnt;
        start_in = 1;
        @(negedge clk);
        start_in = 0;
        cyc = 0;
        while (!(wr_cnt - w0 == 6 && bus.sum_ready_out) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 2000) begin
            n_fail++; $display("FAIL midrst_reach: 7th sum wait not reached");
        end
        rst_n_in = 0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ctl_v !== 8'd0 || addr_v !== 85'd0 || data_v !== 99'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ctl %0h addr %0h data %0h expected 0",
                     ctl_v, addr_v, data_v);
        end
        @(negedge clk);
        rst_n_in = 1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (wr_cnt - w0 != 6) begin
            n_fail++; $display("FAIL midrst_writes: got %0d expected 6", wr_cnt - w0);
        end
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_out);
        end
    endtask

    task automatic test_restart_random();
        int wr, dn; bit tmo; logic b1, e1, bd, ed;
        do_reset();
        for (int i = 0; i < 8; i++) ct_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) w_mem[i] = 3'($urandom_range(0, 7));
        build_ref();
        fill_acc($urandom);
        run_pass(1, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("rand1", wr, dn, tmo, b1, bd);
        for (int a = 0; a < NA; a++) begin
            n_checks++;
            if (acc_mem[a] !== ref_acc[a]) begin
                n_fail++;
                $display("FAIL rand1_acc[%0d]: got %h expected %h", a, acc_mem[a], ref_acc[a]);
            end
        end
        run_pass(0, wr, dn, tmo, b1, e1, bd, ed);
        check_pass("rand2", wr, dn, tmo, b1, bd);
        for (int a = 0; a < NA; a++) begin
            n_checks++;
            if (acc_mem[a] !== ref_acc[a]) begin
                n_fail++;
                $display("FAIL rand2_acc[%0d]: got %h expected %h", a, acc_mem[a], ref_acc[a]);
            end
        end
    endtask

    initial begin
        rst_n_in = 0;
        start_in = 0;
        for (int i = 0; i < 8; i++) begin
            ct_mem[i] = 0;
            ref_acc[i] = 0;
        end
        for (int i = 0; i < 4; i++) w_mem[i] = 0;
        test_reset();
        test_basic();
        test_neg_weight();
        test_stall();
        test_bad_idx();
        test_reset_mid();
        test_restart_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
